// File: rtl/spec_snapshot_streamer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spec_snapshot_streamer
// Captures a 2^ADDR_W-sample ADC frame and streams it to the FX2 EP6 FIFO.
// Revision : 1.0
// ============================================================================
module spec_snapshot_streamer #(
  parameter int SAMPLE_W   = 16,
  parameter int ADDR_W     = 12,
  parameter int DERAND     = 1,
  parameter int SWAP_BYTES = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] adc_data,
  input  logic                adc_valid,
  input  logic                arm,
  input  logic                continuous,
  input  logic                abort,
  input  logic                fx2_ready,
  output logic [15:0]         fx2_fd,
  output logic                slwr_n,
  output logic                slrd_n,
  output logic                sloe_n,
  output logic                pkend_n,
  output logic [1:0]          fifo_adr,
  output logic                busy,
  output logic                frame_done,
  output logic [15:0]         frame_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FILL    = 3'd1,
    S_CHECK   = 3'd2,
    S_STROBE  = 3'd3,
    S_RELEASE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [15:0]         fx2_fd_q, fx2_fd_d;
  logic                slwr_n_q, slwr_n_d;
  logic                frame_done_q, frame_done_d;
  logic [15:0]         frame_count_q, frame_count_d;
  logic                mem_we;
  logic [SAMPLE_W-1:0] derand_w;
  logic [15:0]         sample_ext_w;
  logic [15:0]         rd_word_w;
  logic [15:0]         out_word_w;

  logic [15:0] mem [0:(1<<ADDR_W)-1];

  // LT2208 randomiser: a set LSB means the upper bits were XORed with it.
  always_comb begin
    derand_w = adc_data;
    if (DERAND != 0 && adc_data[0]) begin
      derand_w = adc_data ^ {{(SAMPLE_W-1){1'b1}}, 1'b0};
    end
  end

  generate
    if (SAMPLE_W < 16) begin : g_sext
      assign sample_ext_w = {{(16-SAMPLE_W){derand_w[SAMPLE_W-1]}}, derand_w};
    end else begin : g_full
      assign sample_ext_w = derand_w[15:0];
    end
  endgenerate

  assign rd_word_w  = mem[rd_ptr_q];
  assign out_word_w = (SWAP_BYTES != 0) ? {rd_word_w[7:0], rd_word_w[15:8]} : rd_word_w;

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= sample_ext_w;
    end
  end

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    fx2_fd_d      = fx2_fd_q;
    slwr_n_d      = 1'b1;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    mem_we        = 1'b0;
    if (abort) begin
      state_d  = S_IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arm) begin
            state_d  = S_FILL;
            wr_ptr_d = '0;
          end
        end
        S_FILL: begin
          if (adc_valid) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (wr_ptr_q == LAST_ADDR) begin
              state_d  = S_CHECK;
              rd_ptr_d = '0;
            end
          end
        end
        S_CHECK: begin
          if (fx2_ready) begin
            fx2_fd_d = out_word_w;
            state_d  = S_STROBE;
          end
        end
        S_STROBE: begin
          slwr_n_d = 1'b0;
          state_d  = S_RELEASE;
        end
        S_RELEASE: begin
          if (rd_ptr_q == LAST_ADDR) begin
            frame_done_d  = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
            state_d       = S_DONE;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            state_d  = S_CHECK;
          end
        end
        S_DONE: begin
          if (continuous || arm) begin
            state_d  = S_FILL;
            wr_ptr_d = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fx2_fd_q      <= 16'h0000;
      slwr_n_q      <= 1'b1;
      frame_done_q  <= 1'b0;
      frame_count_q <= 16'h0000;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fx2_fd_q      <= fx2_fd_d;
      slwr_n_q      <= slwr_n_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign fx2_fd      = fx2_fd_q;
  assign slwr_n      = slwr_n_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign busy        = (state_q == S_FILL) || (state_q == S_CHECK) ||
                       (state_q == S_STROBE) || (state_q == S_RELEASE);
  assign slrd_n      = 1'b1;
  assign sloe_n      = 1'b1;
  assign pkend_n     = 1'b1;
  assign fifo_adr    = 2'b10;

endmodule
`default_nettype wire

// File: tb/tb_spec_snapshot_streamer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spec_snapshot_streamer
// Directed bench: a 16-bit derandomising instance and a 14-bit plain instance
// run in lockstep on shared controls.
// Revision : 1.0
// ============================================================================
module tb_spec_snapshot_streamer;

  localparam int          DEPTH  = 256;
  localparam logic [15:0] MARKER = 16'hBEEF;

  logic        clock = 1'b0;
  logic        reset, adc_valid, arm, continuous, abort, fx2_ready;
  logic [15:0] adc_data;
  logic [13:0] adc_data_b;

  logic [15:0] a_fx2_fd, a_frame_count, b_fx2_fd, b_frame_count;
  logic        a_slwr_n, a_slrd_n, a_sloe_n, a_pkend_n, a_busy, a_frame_done;
  logic        b_slwr_n, b_slrd_n, b_sloe_n, b_pkend_n, b_busy, b_frame_done;
  logic [1:0]  a_fifo_adr, b_fifo_adr;

  int n_checks = 0;
  int n_pass   = 0;

  assign adc_data_b = adc_data[13:0];

  spec_snapshot_streamer #(.SAMPLE_W(16), .ADDR_W(8), .DERAND(1), .SWAP_BYTES(1)) u_dut_a (
    .clock(clock), .reset(reset), .adc_data(adc_data), .adc_valid(adc_valid),
    .arm(arm), .continuous(continuous), .abort(abort), .fx2_ready(fx2_ready),
    .fx2_fd(a_fx2_fd), .slwr_n(a_slwr_n), .slrd_n(a_slrd_n), .sloe_n(a_sloe_n),
    .pkend_n(a_pkend_n), .fifo_adr(a_fifo_adr), .busy(a_busy),
    .frame_done(a_frame_done), .frame_count(a_frame_count)
  );

  spec_snapshot_streamer #(.SAMPLE_W(14), .ADDR_W(8), .DERAND(0), .SWAP_BYTES(1)) u_dut_b (
    .clock(clock), .reset(reset), .adc_data(adc_data_b), .adc_valid(adc_valid),
    .arm(arm), .continuous(continuous), .abort(abort), .fx2_ready(fx2_ready),
    .fx2_fd(b_fx2_fd), .slwr_n(b_slwr_n), .slrd_n(b_slrd_n), .sloe_n(b_sloe_n),
    .pkend_n(b_pkend_n), .fifo_adr(b_fifo_adr), .busy(b_busy),
    .frame_done(b_frame_done), .frame_count(b_frame_count)
  );

  always #5 clock = ~clock;

  // Strobe monitor: captures the bus on every low slwr_n sample.
  int          cyc = 0, n_str = 0, n_done = 0, width_err = 0, lock_err = 0;
  logic        prev_slwr = 1'b1;
  logic [15:0] cap_a [0:4095];
  logic [15:0] cap_b [0:4095];
  int          cap_cyc [0:4095];

  always @(negedge clock) begin
    cyc <= cyc + 1;
    if (reset) begin
      prev_slwr <= 1'b1;
    end else begin
      if (a_slwr_n === 1'b0) begin
        if (n_str < 4096) begin
          cap_a[n_str]   <= a_fx2_fd;
          cap_b[n_str]   <= b_fx2_fd;
          cap_cyc[n_str] <= cyc;
        end
        n_str <= n_str + 1;
        if (prev_slwr === 1'b0) width_err <= width_err + 1;
      end
      if (a_frame_done === 1'b1) n_done <= n_done + 1;
      if (a_slwr_n !== b_slwr_n || a_frame_done !== b_frame_done) lock_err <= lock_err + 1;
      prev_slwr <= a_slwr_n;
    end
  end

  function automatic logic [15:0] gen(input int pat, input int i);
    int r;
    case (pat)
      0:       r = i;
      1:       r = (i == 0) ? 32'h2000 : ((i * 257) ^ 32'h5A3C);
      default: r = (i * 37 + pat * 1009) ^ 32'hC35A;
    endcase
    return r[15:0];
  endfunction

  function automatic logic [15:0] exp_a(input logic [15:0] v);
    logic [15:0] w;
    w = v[0] ? (v ^ 16'hFFFE) : v;
    return {w[7:0], w[15:8]};
  endfunction

  function automatic logic [15:0] exp_b(input logic [15:0] v);
    logic [15:0] w;
    w = {{2{v[13]}}, v[13:0]};
    return {w[7:0], w[15:8]};
  endfunction

  task automatic drive_frame(input int pat);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clock);
      arm       = 1'b0;
      adc_valid = 1'b1;
      adc_data  = gen(pat, i);
    end
    @(negedge clock);
    adc_data = MARKER;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clock); #1;
      if (a_frame_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; arm = 1'b0; adc_valid = 1'b0; adc_data = 16'h0;
    continuous = 1'b0; abort = 1'b0; fx2_ready = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    n_checks++;
    if (a_fx2_fd !== 16'h0 || b_fx2_fd !== 16'h0) $display("FAIL reset_fd got %h/%h expected 0000", a_fx2_fd, b_fx2_fd); else n_pass++;
    n_checks++;
    if (a_slwr_n !== 1'b1 || a_frame_done !== 1'b0 || a_busy !== 1'b0)
      $display("FAIL reset_ctrl got slwr_n=%b done=%b busy=%b expected 1 0 0", a_slwr_n, a_frame_done, a_busy);
    else n_pass++;
    n_checks++;
    if (a_frame_count !== 16'h0) $display("FAIL reset_count got %h expected 0000", a_frame_count); else n_pass++;
    n_checks++;
    if ({a_slrd_n, a_sloe_n, a_pkend_n, a_fifo_adr} !== 5'b11110)
      $display("FAIL const_pins got %b expected 11110", {a_slrd_n, a_sloe_n, a_pkend_n, a_fifo_adr});
    else n_pass++;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_ramp;
    int s, d0, gap_bad;
    bit ok;
    s = n_str; d0 = n_done;
    @(negedge clock);
    arm = 1'b1;
    drive_frame(0);
    wait_done(ok);
    n_checks++;
    if (!ok) $display("FAIL ramp_timeout got no frame_done expected one"); else n_pass++;
    n_checks++;
    if (n_str - s !== DEPTH) $display("FAIL ramp_strobes got %0d expected %0d", n_str - s, DEPTH); else n_pass++;
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++;
      if (cap_a[s+i] !== exp_a(gen(0, i)) || cap_b[s+i] !== exp_b(gen(0, i)))
        $display("FAIL ramp_word[%0d] got %h/%h expected %h/%h", i, cap_a[s+i], cap_b[s+i], exp_a(gen(0, i)), exp_b(gen(0, i)));
      else n_pass++;
    end
    n_checks++;
    if (cap_b[s+1] !== 16'h0100 || cap_b[s+255] !== 16'hFF00)
      $display("FAIL ramp_swap got %h,%h expected 0100,FF00", cap_b[s+1], cap_b[s+255]);
    else n_pass++;
    n_checks++;
    if (cap_a[s+3] !== 16'hFDFF || cap_a[s+2] !== 16'h0200)
      $display("FAIL derand got %h,%h expected FDFF,0200", cap_a[s+3], cap_a[s+2]);
    else n_pass++;
    gap_bad = 0;
    for (int i = 0; i < DEPTH - 1; i++) if (cap_cyc[s+i+1] - cap_cyc[s+i] != 3) gap_bad++;
    n_checks++;
    if (gap_bad != 0) $display("FAIL strobe_spacing got %0d bad gaps expected 0", gap_bad); else n_pass++;
    n_checks++;
    if (n_done - d0 !== 1) $display("FAIL ramp_done_pulses got %0d expected 1", n_done - d0); else n_pass++;
    n_checks++;
    if (a_frame_count !== 16'd1 || b_frame_count !== 16'd1)
      $display("FAIL ramp_count got %h/%h expected 0001", a_frame_count, b_frame_count);
    else n_pass++;
    repeat (10) @(negedge clock);
    #1;
    n_checks++;
    if (a_busy !== 1'b0 || n_str - s !== DEPTH) $display("FAIL ramp_hold got busy=%b strobes=%0d expected 0/%0d", a_busy, n_str - s, DEPTH); else n_pass++;
  endtask

  task automatic test_stall;
    int s, stall_bad;
    bit stalled, ok;
    s = n_str; stall_bad = 0; stalled = 1'b0; ok = 1'b0;
    @(negedge clock);
    arm = 1'b1;
    drive_frame(1);
    for (int k = 0; k < 4000; k++) begin
      @(negedge clock); #1;
      if (!stalled && (n_str - s) == 11) begin
        fx2_ready = 1'b0;
        stalled   = 1'b1;
        for (int j = 0; j < 50; j++) begin
          @(negedge clock); #1;
          if (a_slwr_n !== 1'b1 || a_fx2_fd !== exp_a(gen(1, 10)) || b_fx2_fd !== exp_b(gen(1, 10))) stall_bad++;
        end
        fx2_ready = 1'b1;
      end
      if (a_frame_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok || !stalled) $display("FAIL stall_timeout got done=%b stalled=%b expected 1 1", ok, stalled); else n_pass++;
    n_checks++;
    if (stall_bad != 0) $display("FAIL stall_hold got %0d bad cycles expected 0", stall_bad); else n_pass++;
    n_checks++;
    if (n_str - s !== DEPTH) $display("FAIL stall_strobes got %0d expected %0d", n_str - s, DEPTH); else n_pass++;
    n_checks++;
    if (cap_cyc[s+11] - cap_cyc[s+10] <= 50) $display("FAIL stall_gap got %0d expected >50", cap_cyc[s+11] - cap_cyc[s+10]); else n_pass++;
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++;
      if (cap_a[s+i] !== exp_a(gen(1, i)) || cap_b[s+i] !== exp_b(gen(1, i)))
        $display("FAIL stall_word[%0d] got %h/%h expected %h/%h", i, cap_a[s+i], cap_b[s+i], exp_a(gen(1, i)), exp_b(gen(1, i)));
      else n_pass++;
    end
    n_checks++;
    if (cap_b[s] !== 16'h00E0 || cap_a[s] !== 16'h0020)
      $display("FAIL sign_extend got %h/%h expected 0020/00E0", cap_a[s], cap_b[s]);
    else n_pass++;
    n_checks++;
    if (a_frame_count !== 16'd2) $display("FAIL stall_count got %h expected 0002", a_frame_count); else n_pass++;
  endtask

  task automatic test_continuous;
    int s, d0, marker_hits;
    bit ok;
    d0 = n_done; marker_hits = 0;
    @(negedge clock);
    continuous = 1'b1;
    for (int f = 0; f < 3; f++) begin
      s = n_str;
      drive_frame(2 + f);
      wait_done(ok);
      if (f == 2) continuous = 1'b0;
      n_checks++;
      if (!ok || n_str - s !== DEPTH) $display("FAIL cont_frame%0d got done=%b strobes=%0d expected 1/%0d", f, ok, n_str - s, DEPTH); else n_pass++;
      for (int i = 0; i < DEPTH; i++) begin
        if (cap_a[s+i] === exp_a(MARKER) || cap_b[s+i] === exp_b(MARKER)) marker_hits++;
        n_checks++;
        if (cap_a[s+i] !== exp_a(gen(2 + f, i)) || cap_b[s+i] !== exp_b(gen(2 + f, i)))
          $display("FAIL cont_word[%0d][%0d] got %h/%h expected %h/%h", f, i, cap_a[s+i], cap_b[s+i], exp_a(gen(2 + f, i)), exp_b(gen(2 + f, i)));
        else n_pass++;
      end
    end
    n_checks++;
    if (marker_hits != 0) $display("FAIL cont_marker got %0d hits expected 0", marker_hits); else n_pass++;
    n_checks++;
    if (n_done - d0 !== 3) $display("FAIL cont_done_pulses got %0d expected 3", n_done - d0); else n_pass++;
    n_checks++;
    if (a_frame_count !== 16'd5 || b_frame_count !== 16'd5)
      $display("FAIL cont_count got %h/%h expected 0005", a_frame_count, b_frame_count);
    else n_pass++;
    s = n_str;
    repeat (20) @(negedge clock);
    #1;
    n_checks++;
    if (a_busy !== 1'b0 || n_str != s) $display("FAIL cont_stop got busy=%b new_strobes=%0d expected 0/0", a_busy, n_str - s); else n_pass++;
  endtask

  task automatic test_abort;
    int s, d0;
    bit ok, hit;
    s = n_str; d0 = n_done; hit = 1'b0;
    @(negedge clock);
    arm = 1'b1;
    drive_frame(5);
    for (int k = 0; k < 2000; k++) begin
      @(negedge clock); #1;
      if ((n_str - s) == 5) begin
        hit = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!hit) $display("FAIL abort_setup got %0d strobes expected 5", n_str - s); else n_pass++;
    @(negedge clock);
    @(negedge clock); #1;
    abort = 1'b1;
    @(negedge clock); #1;
    abort = 1'b0;
    n_checks++;
    if (a_slwr_n !== 1'b1 || a_busy !== 1'b0 || a_frame_done !== 1'b0)
      $display("FAIL abort_next got slwr_n=%b busy=%b done=%b expected 1 0 0", a_slwr_n, a_busy, a_frame_done);
    else n_pass++;
    n_checks++;
    if (a_frame_count !== 16'd5) $display("FAIL abort_count got %h expected 0005", a_frame_count); else n_pass++;
    repeat (20) @(negedge clock);
    #1;
    n_checks++;
    if (n_str - s !== 5 || n_done != d0 || a_busy !== 1'b0)
      $display("FAIL abort_idle got strobes=%0d done=%0d busy=%b expected 5 0 0", n_str - s, n_done - d0, a_busy);
    else n_pass++;
    s = n_str;
    @(negedge clock);
    arm = 1'b1;
    drive_frame(6);
    wait_done(ok);
    n_checks++;
    if (!ok || n_str - s !== DEPTH) $display("FAIL restart_frame got done=%b strobes=%0d expected 1/%0d", ok, n_str - s, DEPTH); else n_pass++;
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++;
      if (cap_a[s+i] !== exp_a(gen(6, i)) || cap_b[s+i] !== exp_b(gen(6, i)))
        $display("FAIL restart_word[%0d] got %h/%h expected %h/%h", i, cap_a[s+i], cap_b[s+i], exp_a(gen(6, i)), exp_b(gen(6, i)));
      else n_pass++;
    end
    n_checks++;
    if (a_frame_count !== 16'd6 || n_done - d0 !== 1)
      $display("FAIL restart_count got %h pulses=%0d expected 0006/1", a_frame_count, n_done - d0);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_stall();
    test_continuous();
    test_abort();
    n_checks++;
    if (width_err != 0) $display("FAIL strobe_width got %0d wide strobes expected 0", width_err); else n_pass++;
    n_checks++;
    if (lock_err != 0) $display("FAIL lockstep got %0d divergent cycles expected 0", lock_err); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
